// File: rtl/pipes.sv
// Shared pipeline types.
// Holds the fetch/decode handoff record, the fetch FSM state encoding,
// the default reset PC and a helper that forces a PC onto a word boundary.
package pipes;

    localparam logic [63:0] RESET_PC_DEFAULT = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic [31:0] raw_instr;
        logic [63:0] pc;
    } fetch_data_t;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } fetch_state_t;

    // Low two address bits carry no meaning for 32-bit instructions.
    function automatic logic [63:0] align_pc(input logic [63:0] a);
        return a & ~64'd3;
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch stage: one outstanding memory request, one held
// instruction for decode, and redirect handling that discards any response
// belonging to a request made before the redirect.
//
// Ports:
//   clk, resetn            clock, synchronous active-low reset
//   ireq_valid/ireq_addr   fetch request (address word aligned)
//   iresp_data_ok/_data    memory response completing the request
//   out_valid/_ready/_data instruction handoff to decode
//   redirect_valid/_pc     redirect from a later stage
//
// state | meaning
// FETCH | request at pc_q outstanding, response will be kept
// FLUSH | request outstanding, response will be dropped; then go to pend_q
// HOLD  | instruction held in out_data for decode, no request outstanding
module fetch_stage
    import pipes::*;
#(
    parameter logic [63:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        ireq_valid,
    output logic [63:0] ireq_addr,
    input  logic        iresp_data_ok,
    input  logic [31:0] iresp_data,
    output logic        out_valid,
    input  logic        out_ready,
    output fetch_data_t out_data,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc
);

    fetch_state_t state_q, state_d;
    logic [63:0]  pc_q, pc_d;
    logic [63:0]  pend_q, pend_d;
    fetch_data_t  data_q, data_d;
    logic [63:0]  redir_aligned;

    assign redir_aligned = align_pc(redirect_pc);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        data_d  = data_q;
        unique case (state_q)
            FETCH: begin
                if (redirect_valid) begin
                    if (iresp_data_ok) begin
                        // Response and redirect coincide: the bus is free now,
                        // so issue the redirect target immediately.
                        pc_d = redir_aligned;
                    end else begin
                        // Request address must stay put until the response,
                        // so park the target until the stale word returns.
                        pend_d  = redir_aligned;
                        state_d = FLUSH;
                    end
                end else if (iresp_data_ok) begin
                    data_d  = '{raw_instr: iresp_data, pc: pc_q};
                    state_d = HOLD;
                end
            end
            FLUSH: begin
                if (iresp_data_ok) begin
                    pc_d    = redirect_valid ? redir_aligned : pend_q;
                    state_d = FETCH;
                end else if (redirect_valid) begin
                    pend_d = redir_aligned;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redir_aligned;
                    state_d = FETCH;
                end else if (out_ready) begin
                    pc_d    = pc_q + 64'd4;
                    state_d = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= FETCH;
            pc_q    <= align_pc(RESET_PC);
            pend_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            data_q  <= data_d;
        end
    end

    assign ireq_valid = (state_q != HOLD);
    assign ireq_addr  = pc_q;
    assign out_valid  = (state_q == HOLD);
    assign out_data   = data_q;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    import pipes::*;

    logic        clk;
    logic        resetn;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        out_ready;
    logic        redirect_valid;
    logic [63:0] redirect_pc;

    logic        ireq_valid, out_valid;
    logic [63:0] ireq_addr;
    fetch_data_t out_data;

    logic        d2_ireq_valid, d2_out_valid;
    logic [63:0] d2_ireq_addr;
    fetch_data_t d2_out_data;

    fetch_stage dut (
        .clk(clk), .resetn(resetn),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    fetch_stage #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_wrap (
        .clk(clk), .resetn(resetn),
        .ireq_valid(d2_ireq_valid), .ireq_addr(d2_ireq_addr),
        .iresp_data_ok(iresp_data_ok), .iresp_data(iresp_data),
        .out_valid(d2_out_valid), .out_ready(out_ready), .out_data(d2_out_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model of the main instance
    fetch_state_t m_st;
    logic [63:0]  m_pc, m_pend;
    fetch_data_t  sb_q[$];

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return 32'hC0DE_0000 ^ a[31:0] ^ {a[63:48], 16'h0};
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs(input string tag);
        fetch_data_t exp_d;
        chk({tag, ".ireq_valid"}, 128'(ireq_valid), 128'(m_st != HOLD));
        chk({tag, ".out_valid"},  128'(out_valid),  128'(m_st == HOLD));
        if (m_st != HOLD) chk({tag, ".ireq_addr"}, 128'(ireq_addr), 128'(m_pc));
        if (m_st == HOLD) begin
            exp_d = (sb_q.size() > 0) ? sb_q[0] : 'x;
            chk({tag, ".out_data"}, 128'(out_data), 128'(exp_d));
        end
    endtask

    task automatic do_reset(input string tag);
        resetn = 1'b0; iresp_data_ok = 1'b0; iresp_data = '0;
        out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        step();
        resetn = 1'b1;
        m_st = FETCH; m_pc = 64'h0000_0000_8000_0000; m_pend = '0;
        sb_q.delete();
        chk({tag, ".rst_ireq_valid"}, 128'(ireq_valid), 128'(1));
        chk({tag, ".rst_ireq_addr"},  128'(ireq_addr),  128'(64'h8000_0000));
        chk({tag, ".rst_out_valid"},  128'(out_valid),  128'(0));
        chk({tag, ".rst_out_data"},   128'(out_data),   128'(0));
    endtask

    task automatic cycle(input string tag, input logic dok, input logic rdy,
                         input logic rv, input logic [63:0] rpc);
        logic [63:0] tgt;
        tgt = {rpc[63:2], 2'b00};
        iresp_data_ok = dok; iresp_data = instr_of(m_pc);
        out_ready = rdy; redirect_valid = rv; redirect_pc = rpc;
        case (m_st)
            FETCH: begin
                if (rv) begin
                    if (dok) m_pc = tgt;
                    else begin m_pend = tgt; m_st = FLUSH; end
                end else if (dok) begin
                    sb_q.push_back('{raw_instr: instr_of(m_pc), pc: m_pc});
                    m_st = HOLD;
                end
            end
            FLUSH: begin
                if (dok) begin m_pc = rv ? tgt : m_pend; m_st = FETCH; end
                else if (rv) m_pend = tgt;
            end
            default: begin
                if (rv) begin
                    m_pc = tgt; m_st = FETCH; void'(sb_q.pop_front());
                end else if (rdy) begin
                    m_pc = m_pc + 64'd4; m_st = FETCH; void'(sb_q.pop_front());
                end
            end
        endcase
        step();
        check_outputs(tag);
    endtask

    initial begin
        resetn = 1'b0; iresp_data_ok = 1'b0; iresp_data = '0;
        out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;

        // Reset state, plus PC wrap on the second instance
        do_reset("r0");
        chk("wrap.rst_addr", 128'(d2_ireq_addr), 128'(64'hFFFF_FFFF_FFFF_FFFC));
        cycle("wrap.a", 1'b1, 1'b0, 1'b0, '0);
        chk("wrap.hold", 128'(d2_out_valid), 128'(1));
        chk("wrap.hold_pc", 128'(d2_out_data.pc), 128'(64'hFFFF_FFFF_FFFF_FFFC));
        cycle("wrap.b", 1'b0, 1'b1, 1'b0, '0);
        chk("wrap.next_addr", 128'(d2_ireq_addr), 128'(0));
        chk("wrap.next_valid", 128'(d2_ireq_valid), 128'(1));

        // Streaming at full rate
        do_reset("r1");
        for (int i = 0; i < 6; i++) begin
            cycle("stream", 1'b1, 1'b1, 1'b0, '0);
            if (i == 0) chk("stream.pc0", 128'(out_data.pc), 128'(64'h8000_0000));
            if (i == 1) chk("stream.addr1", 128'(ireq_addr), 128'(64'h8000_0004));
            if (i == 3) chk("stream.addr2", 128'(ireq_addr), 128'(64'h8000_0008));
            if (i == 4) chk("stream.pc2", 128'(out_data.pc), 128'(64'h8000_0008));
        end

        // Backpressure in HOLD
        cycle("bp.fill", 1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 5; i++) cycle("bp.stall", 1'b0, 1'b0, 1'b0, '0);
        chk("bp.pc_held", 128'(out_data.pc), 128'(64'h8000_000C));
        cycle("bp.accept", 1'b0, 1'b1, 1'b0, '0);
        chk("bp.next_addr", 128'(ireq_addr), 128'(64'h8000_0010));

        // Redirect in FETCH with delayed response
        cycle("rf.redir", 1'b0, 1'b0, 1'b1, 64'h8000_1002);
        chk("rf.addr_kept", 128'(ireq_addr), 128'(64'h8000_0010));
        cycle("rf.w1", 1'b0, 1'b0, 1'b0, '0);
        cycle("rf.w2", 1'b0, 1'b0, 1'b0, '0);
        cycle("rf.drop", 1'b1, 1'b1, 1'b0, '0);
        chk("rf.new_addr", 128'(ireq_addr), 128'(64'h8000_1000));
        chk("rf.no_out", 128'(out_valid), 128'(0));

        // Multiple redirects during FLUSH, latest wins
        cycle("mf.enter", 1'b0, 1'b0, 1'b1, 64'h300);
        cycle("mf.r1", 1'b0, 1'b0, 1'b1, 64'h100);
        cycle("mf.r2", 1'b0, 1'b0, 1'b1, 64'h200);
        cycle("mf.drop", 1'b1, 1'b0, 1'b0, '0);
        chk("mf.addr", 128'(ireq_addr), 128'(64'h200));
        chk("mf.no_out", 128'(out_valid), 128'(0));

        // Redirect coincident with response in FETCH
        cycle("co", 1'b1, 1'b1, 1'b1, 64'h4442);
        chk("co.addr", 128'(ireq_addr), 128'(64'h4440));
        chk("co.no_out", 128'(out_valid), 128'(0));

        // Redirect while holding, even with out_ready
        cycle("hr.fill", 1'b1, 1'b0, 1'b0, '0);
        cycle("hr.redir", 1'b0, 1'b1, 1'b1, 64'h9000);
        chk("hr.addr", 128'(ireq_addr), 128'(64'h9000));

        // Redirect coincident with response in FLUSH
        cycle("fr.enter", 1'b0, 1'b0, 1'b1, 64'hA000);
        cycle("fr.both", 1'b1, 1'b0, 1'b1, 64'hB000);
        chk("fr.addr", 128'(ireq_addr), 128'(64'hB000));

        // Reset mid-request, late response completes the new RESET_PC fetch
        cycle("mr.pend", 1'b0, 1'b0, 1'b0, '0);
        do_reset("r2");
        cycle("mr.late", 1'b1, 1'b0, 1'b0, '0);
        chk("mr.pc", 128'(out_data.pc), 128'(64'h8000_0000));
        cycle("mr.acc", 1'b0, 1'b1, 1'b0, '0);
        chk("sb.empty", 128'(sb_q.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
